// File: rtl/sp_ram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sp_ram_fifo_ctrl
//
// FIFO controller for a single-port block RAM with no output register and
// WRITE_FIRST behaviour. The controller owns the RAM port (ena/wea/addra/dina)
// and reads back douta. It presents a valid/ready FIFO interface to the user.
// A two-entry output buffer hides the one-cycle RAM read latency.
//
// Only one RAM operation can run per cycle. When reads and writes compete for
// the port, the grant alternates between them.
//
// Optional feature: define SP_FIFO_AFULL_EN to add the registered almost_full
// output and its AFULL_THRESH parameter.
//
// Ports
//   clka, resetn         clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready    write handshake, in_data is the write word
//   out_valid/out_ready  read handshake, out_data is the head word
//   level                words in RAM + read in flight + buffered words
//   ram_ena/ram_wea      RAM enable / write enable
//   ram_addra/ram_dina   RAM address / write data
//   ram_douta            RAM read data (valid the cycle after a read)
//   almost_full          ram_cnt >= AFULL_THRESH, registered (macro only)
// -----------------------------------------------------------------------------
module sp_ram_fifo_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 9
`ifdef SP_FIFO_AFULL_EN
  , parameter int AFULL_THRESH = 4032
`endif
) (
  input  logic              clka,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W+1:0] level,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [DATA_W-1:0] ram_dina,
  input  logic [DATA_W-1:0] ram_douta
`ifdef SP_FIFO_AFULL_EN
  , output logic            almost_full
`endif
);

  typedef enum logic {GRANT_READ = 1'b0, GRANT_WRITE = 1'b1} grant_e;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
  logic              rd_inflight_q;
  logic [1:0]        buf_cnt_q, buf_cnt_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;
  grant_e            last_grant_q, last_grant_d;

  logic rd_want, wr_full, wr_go, rd_go, push, pop;

  // A read is only worth issuing if the word will have a buffer slot when it
  // lands; counting the in-flight read makes buffer overflow impossible.
  assign rd_want = (ram_cnt_q != '0) &&
                   ((buf_cnt_q == 2'd0) || ((buf_cnt_q == 2'd1) && !rd_inflight_q));
  assign wr_full = (ram_cnt_q == DEPTH);

  // in_ready is a function of state only. Yielding to a pending read after a
  // write makes the grants alternate under contention. Gating with resetn
  // keeps the port closed while reset is held.
  assign in_ready = resetn && !wr_full && !(rd_want && (last_grant_q == GRANT_WRITE));
  assign wr_go    = in_valid && in_ready;
  assign rd_go    = rd_want && !wr_go;

  assign ram_ena   = wr_go || rd_go;
  assign ram_wea   = wr_go;
  assign ram_addra = wr_go ? wr_ptr_q : rd_ptr_q;
  assign ram_dina  = in_data;

  // douta is only meaningful in the cycle after a read. After a write it
  // echoes the written word, so it is ignored then.
  assign push      = rd_inflight_q;
  assign out_valid = (buf_cnt_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = buf0_q;

  assign level = {1'b0, ram_cnt_q}
               + {{ADDR_W{1'b0}}, buf_cnt_q}
               + {{(ADDR_W+1){1'b0}}, rd_inflight_q};

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    ram_cnt_d    = ram_cnt_q;
    last_grant_d = last_grant_q;
    if (wr_go) begin
      wr_ptr_d     = wr_ptr_q + 1'b1;
      ram_cnt_d    = ram_cnt_q + 1'b1;
      last_grant_d = GRANT_WRITE;
    end else if (rd_go) begin
      rd_ptr_d     = rd_ptr_q + 1'b1;
      ram_cnt_d    = ram_cnt_q - 1'b1;
      last_grant_d = GRANT_READ;
    end
  end

  // Output buffer: buf0 is always the head. A pop shifts buf1 forward.
  always_comb begin
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    buf_cnt_d = buf_cnt_q;
    case ({push, pop})
      2'b10: begin
        if (buf_cnt_q == 2'd0) buf0_d = ram_douta;
        else                   buf1_d = ram_douta;
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d    = buf1_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b11: begin
        if (buf_cnt_q == 2'd1) begin
          buf0_d = ram_douta;
        end else begin
          buf0_d = buf1_q;
          buf1_d = ram_douta;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // the pre-edge value of the others regardless of evaluation order.
  always_ff @(posedge clka or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ram_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
      buf_cnt_q     <= 2'd0;
      last_grant_q  <= GRANT_READ;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ram_cnt_q     <= ram_cnt_d;
      rd_inflight_q <= rd_go;
      buf_cnt_q     <= buf_cnt_d;
      last_grant_q  <= last_grant_d;
    end
  end

  // NOTE: buffer data is not reset; buf_cnt_q alone decides which entries are
  // meaningful, so the data flops stay plain and cheap.
  always_ff @(posedge clka) begin
    buf0_q <= buf0_d;
    buf1_q <= buf1_d;
  end

`ifdef SP_FIFO_AFULL_EN
  localparam logic [ADDR_W:0] AFULL_LVL = AFULL_THRESH[ADDR_W:0];
  logic almost_full_q;

  always_ff @(posedge clka or negedge resetn) begin
    if (!resetn) almost_full_q <= 1'b0;
    else         almost_full_q <= (ram_cnt_q >= AFULL_LVL);
  end

  assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sp_ram_fifo_ctrl
//
// Bench for sp_ram_fifo_ctrl with a behavioural WRITE_FIRST single-port RAM.
// The monitor samples on the falling edge. Every accepted write is queued as
// the expected output, and every output handshake pops and compares. Directed
// sequences cover reset, ordering, latency, full, streaming and mid-run reset.
// -----------------------------------------------------------------------------
module tb_sp_ram_fifo_ctrl;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 9;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clka = 1'b0;
  logic              resetn = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W+1:0] level;
  logic              ram_ena;
  logic              ram_wea;
  logic [ADDR_W-1:0] ram_addra;
  logic [DATA_W-1:0] ram_dina;
  logic [DATA_W-1:0] ram_douta = '0;
`ifdef SP_FIFO_AFULL_EN
  logic              almost_full;
`endif

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];

  always #5 clka = ~clka;

`ifdef SP_FIFO_AFULL_EN
  sp_ram_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AFULL_THRESH(8)) dut (
`else
  sp_ram_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
`endif
    .clka(clka), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra),
    .ram_dina(ram_dina), .ram_douta(ram_douta)
`ifdef SP_FIFO_AFULL_EN
    , .almost_full(almost_full)
`endif
  );

  // Single-port RAM, no output register, WRITE_FIRST.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clka) begin
    if (ram_ena) begin
      if (ram_wea) begin
        mem[ram_addra] <= ram_dina;
        ram_douta      <= ram_dina;
      end else begin
        ram_douta <= mem[ram_addra];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: handshakes are decided by the values stable before
  // the next rising edge, so the falling edge is a safe sampling point.
  always @(negedge clka) begin
    if (resetn) begin
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dout_unexpected: got 0x%0h, expected no output", out_data);
        end else begin
          check("dout", {23'd0, out_data}, {23'd0, exp_q.pop_front()});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
      if (dut.rd_inflight_q && dut.buf_cnt_q == 2'd2 && !(out_valid && out_ready)) begin
        errors++;
        $display("FAIL buf_overflow: got push into full buffer, expected none");
      end
    end
  end

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    repeat (3) tick();
    resetn = 1'b1;
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      @(negedge clka);
      n++;
    end while (!in_ready && n < 50);
    check("push_accept", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Continuous in_valid; data increments after each accepted word.
  task automatic stream_fill(input int n_words, input logic [DATA_W-1:0] base);
    int acc = 0;
    int guard = 0;
    logic take;
    in_valid = 1'b1;
    in_data  = base;
    while (acc < n_words && guard < 3 * n_words + 20) begin
      @(negedge clka);
      guard++;
      take = in_ready;
      tick();
      if (take) begin
        acc++;
        in_data = in_data + 1'b1;
      end
    end
    in_valid = 1'b0;
    check("fill_count", acc, n_words);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    tick();
    check("drain_level", {18'd0, level}, 32'd0);
  endtask

  initial begin
    int n;
    int acc;
    int out_start;
    logic take;

    // Reset state, with in_valid held high to prove nothing leaks out.
    resetn    = 1'b0;
    in_valid  = 1'b1;
    in_data   = 9'h1FF;
    out_ready = 1'b1;
    repeat (2) tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_level", {18'd0, level}, 32'd0);
    check("rst_ram_ena", {31'd0, ram_ena}, 32'd0);
    check("rst_ram_wea", {31'd0, ram_wea}, 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    resetn    = 1'b1;
    tick();

    // Three words with out_ready low: two buffered, one in RAM.
    push(9'h001);
    push(9'h002);
    push(9'h003);
    repeat (3) tick();
    check("three_level", {18'd0, level}, 32'd3);
    check("three_out_valid", {31'd0, out_valid}, 32'd1);
    check("three_head", {23'd0, out_data}, 32'h001);
    drain(50);

    // Latency of a single word into an empty FIFO.
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 9'h0AB;
    n = 0;
    do begin
      @(negedge clka);
      n++;
    end while (!in_ready && n < 10);
    check("lat_accept", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("lat_edge_n", {31'd0, out_valid}, 32'd0);
    tick();
    check("lat_edge_n1", {31'd0, out_valid}, 32'd0);
    tick();
    check("lat_edge_n2", {31'd0, out_valid}, 32'd1);
    check("lat_data", {23'd0, out_data}, 32'h0AB);
    drain(10);

    // Fill completely: RAM full plus two buffered words.
    do_reset();
    stream_fill(DEPTH + 2, 9'h000);
    repeat (3) tick();
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_level", {18'd0, level}, DEPTH + 2);
    check("full_ram_cnt", {19'd0, dut.ram_cnt_q}, DEPTH);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 2) begin
      tick();
      n++;
    end
    check("full_recover", {31'd0, in_ready}, 32'd1);
    drain(3 * DEPTH);

    // Sustained streaming: the port alternates write/read every cycle.
    do_reset();
    out_start = out_cnt;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 9'h100;
    acc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clka);
      check("stream_ena", {31'd0, ram_ena}, 32'd1);
      check("stream_wea", {31'd0, ram_wea}, (i % 2 == 0) ? 32'd1 : 32'd0);
      take = in_ready;
      tick();
      if (take) begin
        acc++;
        in_data = in_data + 1'b1;
      end
    end
    in_valid = 1'b0;
    drain(20);
    check("stream_in_words", acc, 100);
    check("stream_out_words", out_cnt - out_start, 100);

    // Reset in the middle of operation discards everything.
    do_reset();
    stream_fill(17, 9'h020);
    repeat (3) tick();
    check("mid_level", {18'd0, level}, 32'd17);
    check("mid_out_valid", {31'd0, out_valid}, 32'd1);
    #2;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_level", {18'd0, level}, 32'd0);
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    out_ready = 1'b1;
    push(9'h155);
    drain(20);

`ifdef SP_FIFO_AFULL_EN
    // Threshold 8: two words sit in the buffer, so the tenth word brings the
    // RAM count to 8.
    do_reset();
    for (int k = 0; k < 9; k++) push(9'h040 + 9'(k));
    check("af_at_7", {31'd0, almost_full}, 32'd0);
    push(9'h049);
    check("af_edge_n", {31'd0, almost_full}, 32'd0);
    tick();
    check("af_edge_n1", {31'd0, almost_full}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check("af_hold", {31'd0, almost_full}, 32'd1);
    tick();
    check("af_clear", {31'd0, almost_full}, 32'd0);
    do_reset();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
